// File: rtl/mem_access.sv
// mem_access: load/store unit bridging the pipeline to an Avalon-MM data port.
// Handles MIPS-style byte/half/word loads and stores, including the unaligned
// LWL/LWR merges, with misalignment detection and pipeline stall generation.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   data_read, data_write        load/store request, level-held while stall=1
//   opcode[5:0]                  instruction opcode
//   addr[31:0]                   effective byte address
//   store_data[31:0]             rt value for stores
//   rt_old[31:0]                 current rt value for LWL/LWR merges
//   avm_address/read/write/byteenable/writedata   bus request outputs
//   avm_readdata, avm_waitrequest                 bus response inputs
//   stall                        freeze pipeline
//   load_result[31:0]            registered write-back value
//   load_valid                   one-cycle pulse, load_result valid
//   addr_err                     one-cycle misalignment flag (combinational)
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        stall,
    output logic [31:0] load_result,
    output logic        load_valid,
    output logic        addr_err
);

    localparam logic [5:0] OpLb  = 6'd32;
    localparam logic [5:0] OpLh  = 6'd33;
    localparam logic [5:0] OpLwl = 6'd34;
    localparam logic [5:0] OpLw  = 6'd35;
    localparam logic [5:0] OpLbu = 6'd36;
    localparam logic [5:0] OpLhu = 6'd37;
    localparam logic [5:0] OpLwr = 6'd38;
    localparam logic [5:0] OpSb  = 6'd40;
    localparam logic [5:0] OpSh  = 6'd41;
    localparam logic [5:0] OpSw  = 6'd43;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] rt_old_q, rt_old_d;
    logic        is_load_q, is_load_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_write_q, avm_write_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_result_q, load_result_d;
    logic        load_valid_q, load_valid_d;

    logic        req;
    logic        misalign;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] load_word;

    assign req = data_read | data_write;

    // Misalignment, byte enables and write data come from the live inputs so
    // they can be registered on the IDLE->REQ transition.
    always_comb begin
        misalign = 1'b0;
        be_in    = 4'b1111;
        wdata_in = 32'h0;
        case (opcode)
            OpLh, OpLhu: misalign = addr[0];
            OpLw:        misalign = addr[1:0] != 2'b00;
            OpSb: begin
                be_in    = 4'b0001 << addr[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            OpSh: begin
                misalign = addr[0];
                be_in    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
            end
            OpSw: begin
                misalign = addr[1:0] != 2'b00;
                wdata_in = store_data;
            end
            default: ;
        endcase
    end

    // Load extraction from the bus word, using the latched request.
    always_comb begin
        logic [1:0]  k;
        logic [7:0]  b;
        logic [15:0] h;
        logic [5:0]  sh_lwl;
        logic [5:0]  sh_mask;
        logic [5:0]  sh_lwr;
        k       = addr_q[1:0];
        b       = avm_readdata[8*k +: 8];
        h       = addr_q[1] ? avm_readdata[31:16] : avm_readdata[15:0];
        sh_lwl  = {1'b0, 2'd3 - k, 3'b000};
        // 8*(k+1) reaches 32 when k=3, so the mask shifts fully out to zero.
        sh_mask = ({4'b0, k} + 6'd1) << 3;
        sh_lwr  = {1'b0, k, 3'b000};
        case (opcode_q)
            OpLb:    load_word = {{24{b[7]}}, b};
            OpLbu:   load_word = {24'h0, b};
            OpLh:    load_word = {{16{h[15]}}, h};
            OpLhu:   load_word = {16'h0, h};
            OpLwl:   load_word = (avm_readdata << sh_lwl)
                               | (rt_old_q & (32'hFFFF_FFFF >> sh_mask));
            OpLwr:   load_word = (avm_readdata >> sh_lwr)
                               | (rt_old_q & ~(32'hFFFF_FFFF >> sh_lwr));
            default: load_word = avm_readdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        addr_d        = addr_q;
        store_data_d  = store_data_q;
        rt_old_d      = rt_old_q;
        is_load_d     = is_load_q;
        avm_read_d    = avm_read_q;
        avm_write_d   = avm_write_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        load_result_d = load_result_q;
        load_valid_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req && !misalign) begin
                    opcode_d     = opcode;
                    addr_d       = addr;
                    store_data_d = store_data;
                    rt_old_d     = rt_old;
                    is_load_d    = data_read;
                    avm_read_d   = data_read;
                    avm_write_d  = !data_read;
                    be_d         = be_in;
                    wdata_d      = wdata_in;
                    state_d      = StReq;
                end
            end
            StReq: begin
                if (!avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    be_d        = 4'b0000;
                    state_d     = StDone;
                    if (is_load_q) begin
                        load_result_d = load_word;
                        load_valid_d  = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            opcode_q      <= 6'h0;
            addr_q        <= 32'h0;
            store_data_q  <= 32'h0;
            rt_old_q      <= 32'h0;
            is_load_q     <= 1'b0;
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            be_q          <= 4'b0000;
            wdata_q       <= 32'h0;
            load_result_q <= 32'h0;
            load_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            addr_q        <= addr_d;
            store_data_q  <= store_data_d;
            rt_old_q      <= rt_old_d;
            is_load_q     <= is_load_d;
            avm_read_q    <= avm_read_d;
            avm_write_q   <= avm_write_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            load_result_q <= load_result_d;
            load_valid_q  <= load_valid_d;
        end
    end

    // rst_n gating keeps the combinational flags low while reset is asserted.
    assign stall    = rst_n & (((state_q == StIdle) & req & !misalign) | (state_q == StReq));
    assign addr_err = rst_n & (state_q == StIdle) & req & misalign;

    assign avm_address    = {addr_q[31:2], 2'b00};
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;
    assign load_result    = load_result_q;
    assign load_valid     = load_valid_q;

endmodule
